// File: rtl/hsv_core_writeback_busy_release.sv
// Release side of issue-stage hazard tracking: per-register in-flight write counters.
// Optional macro HSV_WB_BUSY_BYPASS_EN frees busy_mask in the writeback cycle of a last write.
module hsv_core_writeback_busy_release #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                        clk_core,
  input  logic                        rst_core_n,
  input  logic                        flush_req,
  input  logic                        issue_valid,
  input  logic [NUM_REGS-1:0]         issue_rd_mask,
  output logic                        issue_ready,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_rd_addr,
  output logic [NUM_REGS-1:0]         busy_mask,
  output logic                        underflow_err
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntZero = '0;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [NUM_REGS-1:0][CNT_W-1:0] r_cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt_d;
  logic                           r_err;
  logic                           w_err_set;
  logic [NUM_REGS-1:0]            w_wb_hit;
  logic [NUM_REGS-1:0]            w_inc;
  logic [NUM_REGS-1:0]            w_full;
  logic [NUM_REGS-1:0]            w_block;
  logic                           w_issue_fire;

  // x0 never hits, never counts and never blocks.
  always_comb begin
    w_wb_hit = '0;
    w_full   = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      w_wb_hit[r] = wb_valid & (wb_rd_addr == AW'(r)) & ~flush_req;
      w_full[r]   = (r_cnt[r] == CntMax);
    end
  end

  always_comb begin
    w_block = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      w_block[r] = issue_rd_mask[r] & w_full[r] & ~w_wb_hit[r];
    end
  end

  assign issue_ready  = ~(|w_block);
  assign w_issue_fire = issue_valid & issue_ready & ~flush_req;

  always_comb begin
    w_inc = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      w_inc[r] = w_issue_fire & issue_rd_mask[r];
    end
  end

  // Flush wins over inc/dec; a forced increment at max holds rather than wrapping.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_err_set = 1'b0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (flush_req) begin
        w_cnt_d[r] = CntZero;
      end else if (w_inc[r] && !w_wb_hit[r]) begin
        if (r_cnt[r] != CntMax) begin
          w_cnt_d[r] = r_cnt[r] + CntOne;
        end
      end else if (!w_inc[r] && w_wb_hit[r]) begin
        if (r_cnt[r] != CntZero) begin
          w_cnt_d[r] = r_cnt[r] - CntOne;
        end else begin
          w_err_set = 1'b1;
        end
      end
    end
    w_cnt_d[0] = CntZero;
  end

  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_err <= r_err | w_err_set;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
`ifdef HSV_WB_BUSY_BYPASS_EN
      busy_mask[r] = (r_cnt[r] != CntZero) & ~(w_wb_hit[r] & (r_cnt[r] == CntOne));
`else
      busy_mask[r] = (r_cnt[r] != CntZero);
`endif
    end
  end

  assign underflow_err = r_err;

endmodule

// File: tb/tb_hsv_core_writeback_busy_release.sv
// Table-driven self-checking bench for hsv_core_writeback_busy_release (NUM_REGS=32, CNT_W=2).
module tb_hsv_core_writeback_busy_release;

  logic        clk_core = 1'b0;
  logic        rst_core_n;
  logic        flush_req;
  logic        issue_valid;
  logic [31:0] issue_rd_mask;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] busy_mask;
  logic        underflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  hsv_core_writeback_busy_release #(
    .NUM_REGS(32),
    .CNT_W   (2)
  ) dut (
    .clk_core     (clk_core),
    .rst_core_n   (rst_core_n),
    .flush_req    (flush_req),
    .issue_valid  (issue_valid),
    .issue_rd_mask(issue_rd_mask),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_rd_addr   (wb_rd_addr),
    .busy_mask    (busy_mask),
    .underflow_err(underflow_err)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] mask;
    logic        wv;
    logic [4:0]  wa;
    logic        rdy;   // issue_ready before the edge
    logic [31:0] busy;  // busy_mask after the edge
    logic        err;   // underflow_err after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic fl, logic iv, logic [31:0] mask, logic wv, logic [4:0] wa,
                              logic rdy, logic [31:0] busy, logic err);
    vec_t v;
    v.fl = fl; v.iv = iv; v.mask = mask; v.wv = wv; v.wa = wa;
    v.rdy = rdy; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] mask,
                       input logic wv, input logic [4:0] wa);
    flush_req     = fl;
    issue_valid   = iv;
    issue_rd_mask = mask;
    wb_valid      = wv;
    wb_rd_addr    = wa;
  endtask

  // Entered #1 after a posedge; returns #1 after the next posedge.
  task automatic step(input string tag, input vec_t v);
    drive(v.fl, v.iv, v.mask, v.wv, v.wa);
    #1;
    check({tag, "_ready"}, {31'd0, issue_ready}, {31'd0, v.rdy});
    @(posedge clk_core);
    #1;
    check({tag, "_busy"}, busy_mask, v.busy);
    check({tag, "_err"}, {31'd0, underflow_err}, {31'd0, v.err});
  endtask

  localparam logic [31:0] B3  = 32'h0000_0008;
  localparam logic [31:0] B4  = 32'h0000_0010;
  localparam logic [31:0] B5  = 32'h0000_0020;
  localparam logic [31:0] B7  = 32'h0000_0080;
  localparam logic [31:0] B8  = 32'h0000_0100;
  localparam logic [31:0] B10 = 32'h0000_0400;
  localparam logic [31:0] B31 = 32'h8000_0000;

  initial begin
    vec_t x7_issue, x7_drain;
    logic exp_bypass_busy7;

    //            fl    iv    mask wv    wa     rdy   busy              err
    tbl.push_back(mk(1'b0, 1'b1, B5,  1'b0, 5'd0,  1'b1, B5,              1'b0));
    tbl.push_back(mk(1'b0, 1'b0, '0,  1'b1, 5'd5,  1'b1, '0,              1'b0));
    tbl.push_back(mk(1'b0, 1'b1, B10, 1'b0, 5'd0,  1'b1, B10,             1'b0));
    tbl.push_back(mk(1'b0, 1'b1, B10, 1'b0, 5'd0,  1'b1, B10,             1'b0));
    tbl.push_back(mk(1'b0, 1'b1, B10, 1'b0, 5'd0,  1'b1, B10,             1'b0));  // cnt10=3
    tbl.push_back(mk(1'b0, 1'b1, B10, 1'b0, 5'd0,  1'b0, B10,             1'b0));  // full
    tbl.push_back(mk(1'b0, 1'b0, B10, 1'b0, 5'd0,  1'b0, B10,             1'b0));  // ready ignores valid
    tbl.push_back(mk(1'b0, 1'b1, '0,  1'b0, 5'd0,  1'b1, B10,             1'b0));  // no rd
    tbl.push_back(mk(1'b0, 1'b1, B10, 1'b1, 5'd10, 1'b1, B10,             1'b0));  // inc+dec, stays 3
    tbl.push_back(mk(1'b0, 1'b0, '0,  1'b1, 5'd10, 1'b1, B10,             1'b0));  // 2
    tbl.push_back(mk(1'b0, 1'b0, '0,  1'b1, 5'd10, 1'b1, B10,             1'b0));  // 1
    tbl.push_back(mk(1'b0, 1'b0, '0,  1'b1, 5'd10, 1'b1, '0,              1'b0));  // 0
    tbl.push_back(mk(1'b0, 1'b1, B3,  1'b0, 5'd0,  1'b1, B3,              1'b0));
    tbl.push_back(mk(1'b0, 1'b1, B4,  1'b0, 5'd0,  1'b1, B3 | B4,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, B31, 1'b0, 5'd0,  1'b1, B3 | B4 | B31,   1'b0));
    tbl.push_back(mk(1'b1, 1'b1, B8,  1'b1, 5'd3,  1'b1, '0,              1'b0));  // flush wins
    tbl.push_back(mk(1'b0, 1'b1, B3,  1'b0, 5'd0,  1'b1, B3,              1'b0));
    tbl.push_back(mk(1'b0, 1'b0, '0,  1'b1, 5'd3,  1'b1, '0,              1'b0));
    tbl.push_back(mk(1'b0, 1'b0, '0,  1'b1, 5'd12, 1'b1, '0,              1'b1));  // underflow
    tbl.push_back(mk(1'b1, 1'b0, '0,  1'b0, 5'd0,  1'b1, '0,              1'b1));  // sticky over flush
    tbl.push_back(mk(1'b0, 1'b1, 32'h1, 1'b1, 5'd0, 1'b1, '0,             1'b1));  // x0 ignored

    rst_core_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 5'd0);
    repeat (2) @(posedge clk_core);
    #1;
    rst_core_n = 1'b1;
    check("rst_busy", busy_mask, '0);
    check("rst_err", {31'd0, underflow_err}, 32'd0);
    check("rst_ready", {31'd0, issue_ready}, 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("v%0d", i), tbl[i]);
    end

    // Same-cycle issue and writeback of x7 at cnt=1: counter holds, bypass frees busy early.
    x7_issue = mk(1'b0, 1'b1, B7, 1'b0, 5'd0, 1'b1, B7, 1'b1);
    step("x7_first", x7_issue);
    drive(1'b0, 1'b1, B7, 1'b1, 5'd7);
    #1;
`ifdef HSV_WB_BUSY_BYPASS_EN
    exp_bypass_busy7 = 1'b0;
`else
    exp_bypass_busy7 = 1'b1;
`endif
    check("x7_same_ready", {31'd0, issue_ready}, 32'd1);
    check("x7_same_busy_now", {31'd0, busy_mask[7]}, {31'd0, exp_bypass_busy7});
    @(posedge clk_core);
    #1;
    check("x7_same_busy_after", busy_mask, B7);
    x7_drain = mk(1'b0, 1'b0, '0, 1'b1, 5'd7, 1'b1, '0, 1'b1);
    step("x7_drain", x7_drain);

    // Reset clears the sticky error.
    drive(1'b0, 1'b0, '0, 1'b0, 5'd0);
    rst_core_n = 1'b0;
    @(posedge clk_core);
    #1;
    rst_core_n = 1'b1;
    check("rst2_err", {31'd0, underflow_err}, 32'd0);
    check("rst2_busy", busy_mask, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
